// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch-to-decode payload type.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, occupancy count and a head that reads 0 when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests,
// prefetch buffering toward decode, and redirect with stale-response dropping.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] rsp_pc;
  logic            credit;
  logic            req_fire;
  logic            push_out;
  logic            pop_out;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Buffered plus in-flight fetches never exceed DEPTH.
  assign credit         = (SW'(outstanding) + SW'(fifo_count)) < SW'(DEPTH);
  assign imem_req_valid = credit && !rst;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  // Responses in a redirect cycle or while draining stale fetches are discarded.
  assign push_out   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign out_valid = (fifo_count != '0) && !redirect_valid;
  assign pop_out   = out_valid && out_ready;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      drop_cnt <= outstanding_next;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // PC of every in-flight request; its occupancy is the outstanding count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .head      (rsp_pc),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push_out),
    .push_data (push_entry),
    .pop       (pop_out),
    .head      (head_entry),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;

  int          mem_lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  int          accepted;
  logic        hs;
  logic [31:0] hs_addr;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: a request accepted in cycle c answers in cycle c+mem_lat.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    cyc            = 0;
    accepted       = 0;
    forever begin
      @(posedge clk);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      #1;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        cyc            = 0;
        accepted       = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else begin
        if (hs) begin
          mq_addr.push_back(hs_addr);
          mq_due.push_back(cyc + mem_lat);
          accepted++;
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = 32'h0;
        end
        cyc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Leaves the bench just after reset release, in cycle 0.
  task automatic do_reset(input int lat);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL reset_req_addr got=%h exp=00000000", imem_req_addr);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      failures++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_pc, out_instr);
    end
    do_reset(1);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL reset_release_req got=%0b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    int max_occ;
    int occ;
    logic [31:0] exp_pc;
    do_reset(1);
    max_occ = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      occ = mq_addr.size() + int'(imem_rsp_valid);
      if (occ > max_occ) max_occ = occ;
      checks++;
      if (k < 2) begin
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL seq_latency cycle=%0d out_valid=%0b exp=0", k, out_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL seq_stream cycle=%0d got=%0b/%h/%h exp=1/%h/%h",
                   k, out_valid, out_pc, out_instr, exp_pc, mem_word(exp_pc));
        end
      end
    end
    checks++;
    if (max_occ > 3) begin
      failures++; $display("FAIL seq_outstanding got=%0d exp<=3", max_occ);
    end
  endtask

  task automatic test_backpressure();
    int got;
    logic [31:0] exp_pc;
    do_reset(1);
    out_ready = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || accepted != 4) begin
      failures++; $display("FAIL bp_stall req_valid=%0b accepted=%0d exp=0/4", imem_req_valid, accepted);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL bp_head got=%0b/%h exp=1/00000000", out_valid, out_pc);
    end
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 30 && got < 6; k++) begin
      if (out_valid && out_ready) begin
        exp_pc = 32'(4 * got);
        checks++;
        if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
          failures++; $display("FAIL bp_drain idx=%0d got=%h/%h exp=%h/%h",
                               got, out_pc, out_instr, exp_pc, mem_word(exp_pc));
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 6) begin
      failures++; $display("FAIL bp_drain_count got=%0d exp=6", got);
    end
  endtask

  task automatic test_redirect_drop();
    int found;
    int fcyc;
    logic [31:0] fpc;
    logic [31:0] finstr;
    do_reset(3);
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rd_out_valid got=%0b exp=0", out_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100 || accepted != 2) begin
      failures++; $display("FAIL rd_new_req got=%0b/%h acc=%0d exp=1/00000100/2",
                           imem_req_valid, imem_req_addr, accepted);
    end
    found = 0; fcyc = 0; fpc = 32'h0; finstr = 32'h0;
    for (int k = 3; k < 16 && found == 0; k++) begin
      if (k > 3) @(negedge clk);
      if (out_valid) begin
        found = 1; fcyc = k; fpc = out_pc; finstr = out_instr;
      end
    end
    checks++;
    if (found != 1 || fpc !== 32'h0000_0100 || finstr !== mem_word(32'h0000_0100)) begin
      failures++; $display("FAIL rd_first_out found=%0d got=%h/%h exp=00000100/%h",
                           found, fpc, finstr, mem_word(32'h0000_0100));
    end
    checks++;
    if (fcyc != 7) begin
      failures++; $display("FAIL rd_first_cycle got=%0d exp=7", fcyc);
    end
  endtask

  task automatic test_redirect_collision();
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL col_pre got=%0b/%h/%0b exp=1/00000004/1", out_valid, out_pc, imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL col_redirect_cycle out_valid=%0b exp=0", out_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_addr !== 32'h0000_0200) begin
      failures++; $display("FAIL col_r1 got=%0b/%h exp=0/00000200", out_valid, imem_req_addr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL col_r2 out_valid=%0b exp=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0200 || out_instr !== mem_word(32'h0000_0200)) begin
      failures++; $display("FAIL col_r3 got=%0b/%h/%h exp=1/00000200/%h",
                           out_valid, out_pc, out_instr, mem_word(32'h0000_0200));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int got;
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== exp_pc[got] || out_instr !== mem_word(exp_pc[got])) begin
          failures++; $display("FAIL wrap idx=%0d got=%h/%h exp=%h/%h",
                               got, out_pc, out_instr, exp_pc[got], mem_word(exp_pc[got]));
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 3) begin
      failures++; $display("FAIL wrap_count got=%0d exp=3", got);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    int fcyc;
    do_reset(3);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || (mq_addr.size() + int'(imem_rsp_valid)) != 3) begin
      failures++; $display("FAIL mid_pre got=%0b/%h occ=%0d exp=1/00000000/3",
                           out_valid, out_pc, mq_addr.size() + int'(imem_rsp_valid));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL mid_reset got=%0b/%h/%0b/%h exp=0/00000000/0/00000000",
                           out_valid, out_pc, imem_req_valid, imem_req_addr);
    end
    mem_lat   = 1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL mid_restart_req got=%0b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
    end
    found = 0; fcyc = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid) begin
        found = 1; fcyc = k;
        checks++;
        if (out_pc !== 32'h0 || out_instr !== mem_word(32'h0) || fcyc != 2) begin
          failures++; $display("FAIL mid_restart_out got=%h/%h cyc=%0d exp=00000000/%h/2",
                               out_pc, out_instr, fcyc, mem_word(32'h0));
        end
      end
    end
    checks++;
    if (found != 1) begin
      failures++; $display("FAIL mid_restart_timeout found=%0d exp=1", found);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding `decode_unit`. It generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Returned instructions are buffered in a small prefetch FIFO and presented to decode with their PC over a valid/ready handshake. A redirect port, driven by branch/jump resolution, flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: prefetch FIFO entries and maximum outstanding-plus-buffered fetches; power of 2, range 2..8.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction.
- `redirect_valid`  in  1  single-cycle pulse that restarts fetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
- `out_valid`  out  1  decode-side instruction valid.
- `out_ready`  in  1  decode accepts the instruction.
- `out_pc`  out  32  PC of the head instruction.
- `out_instr`  out  32  head instruction word.

## Operation
- State: `fetch_pc` (32), `outstanding` count (0..DEPTH), `drop_cnt` (0..DEPTH), FIFO of {pc, instr}.
- A pc queue of DEPTH entries tracks the address of each in-flight request, so each response is paired with its PC.
- Request issue condition: `outstanding + fifo_count < DEPTH`, using registered values only. `imem_req_valid` = issue condition. `imem_req_addr` = `fetch_pc`.
- On request handshake, `fetch_pc` advances by 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0), and `outstanding` increments.
- On response: `outstanding` decrements. If `drop_cnt` > 0, the data is discarded and `drop_cnt` decrements. Otherwise the {pc, instr} pair is pushed to the FIFO.
- Output: `out_valid` = FIFO not empty AND NOT `redirect_valid`. A pop occurs on `out_valid && out_ready`.
- Redirect, which takes priority over every other event in the same cycle:
  - FIFO is cleared.
  - `fetch_pc` is loaded with {`redirect_pc`[31:2], 2'b00}.
  - `drop_cnt` is loaded with the post-cycle `outstanding`, i.e. prior outstanding + any request accepted this cycle − any response arriving this cycle. A response arriving in the redirect cycle is itself dropped.
  - If `drop_cnt` > 0 in the redirect cycle, that cycle's response is dropped and counted against the old count before the reload.
- Simultaneous push and pop are allowed on a full FIFO. Push never overflows, because the credit rule bounds occupancy to DEPTH.
- Reset mid-operation clears all state immediately. The memory is reset by the same `rst`, so no stale responses follow.

## Timing
- Reset values: `imem_req_valid` 0 while `rst` is high. `imem_req_addr` = RESET_PC. `out_valid` 0. `out_pc` 0. `out_instr` 0. `outstanding`, `drop_cnt` and FIFO count are 0.
- `imem_req_valid` rises in the first cycle after `rst` deasserts.
- Latency: a response in cycle N produces `out_valid` in N+1; there is no FIFO bypass. A request accepted at T with a 1-cycle memory produces `out_valid` at T+2.
- Throughput: 1 instruction/cycle sustained with a 1-cycle memory and DEPTH ≥ 3. DEPTH=2 achieves 2 per 3 cycles.
- Redirect pulse at cycle R:
  - The first request to the new PC is issued at R+1 if credits allow.
  - Its instruction can be at the output no earlier than R+3.
- `out_pc` / `out_instr` are stable while `out_valid && !out_ready`. They are driven to 0 when the FIFO is empty.

## Structure
- Shared package `riscv_pkg`: `XLEN` = 32, `ILEN` = 32, `PC_STEP` = 4, and the default `RESET_PC` constant used by both the core and this block.
- Sub-module `fetch_fifo`: a synchronous FIFO of width 64 and depth DEPTH, with push, pop, clear, count, and registered head outputs. Instantiate it once for the output queue. The pc queue for in-flight requests is a second instance of width 32.

## Test plan
- Reset release, memory always ready with 1-cycle latency, `out_ready` = 1 → outputs PCs 0, 4, 8, … on consecutive cycles starting 2 cycles after the first request; never more than 3 fetches outstanding.
- `out_ready` held 0 for 10 cycles → requests stop once 4 fetches are buffered or in flight; on release, 0, 4, 8, 12 drain in order with no loss or duplication.
- Memory latency 3 cycles with 2 fetches outstanding, redirect to 32'h0000_0103 → both stale responses dropped; next output is pc 32'h0000_0100 carrying the data fetched from 0x100.
- Redirect in the same cycle as a request handshake and a response → that response dropped, the accepted request's response dropped, and `out_valid` is 0 in the redirect cycle.
- Redirect to 32'hFFFF_FFF8 → outputs pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` while 3 fetches are outstanding and the FIFO holds 1 entry → same cycle `out_valid` = 0; after release, fetch restarts at RESET_PC.
